de10lite_sopc_rst_seq: RTL and testbench
========================================

# de10lite_sopc_rst_seq

Reset sequencer directly downstream of the SoPC PLL. It consumes the PLL `locked` indication, qualifies it over a stable window, and releases a staged pair of resets in the 20 MHz core clock domain: interconnect/peripheral reset first, then SCR1 core reset. It re-asserts reset on lock loss, tracks the cause of the last reset, and optionally supports a software-requested core-only reset.

## Interface
- `LOCK_STABLE_CYCLES`, 1024: consecutive cycles synchronized lock must stay high before release starts; ≥1
- `SYS_HOLD_CYCLES`, 16: cycles `sys_rst` stays high after the lock window; ≥1
- `CORE_DELAY_CYCLES`, 16: cycles between `sys_rst` and `core_rst` deassertion; also the length of a software reset; ≥1
- `SYNC_STAGES`, 2: flops in the `pll_locked` synchronizer; ≥2
- `clk`  in  1  PLL `outclk_0` (core clock)
- `rst`  in  1  asynchronous, active-high reset
- `pll_locked`  in  1  PLL lock; asynchronous to `clk`
- `sw_rst_req`  in  1  synchronous single-cycle core-reset request
- `sys_rst`  out  1  interconnect/peripheral reset, active-high
- `core_rst`  out  1  SCR1 core reset, active-high
- `ready`  out  1  high only in RUN
- `rst_cause`  out  2  cause of last reset: 0 POR, 1 LOCK_LOSS, 2 SW, 3 reserved

## Operation
- Reset values: state WAIT_LOCK, counter 0, synchronizer 0, `sys_rst`=1, `core_rst`=1, `ready`=0, `rst_cause`=0. Outputs assert asynchronously with `rst` and deassert only on `clk` edges.
- `lock_s` is the last stage of the synchronizer.
- WAIT_LOCK: `sys_rst`=1, `core_rst`=1. On `lock_s`=1, go to STABLE with counter cleared.
- STABLE: counts cycles while `lock_s`=1. If `lock_s`=0, return to WAIT_LOCK. After LOCK_STABLE_CYCLES cycles, go to SYS_HOLD.
- SYS_HOLD: `sys_rst` remains 1. After SYS_HOLD_CYCLES cycles, go to CORE_HOLD.
- CORE_HOLD: `sys_rst`=0, `core_rst`=1. After CORE_DELAY_CYCLES cycles, go to RUN.
- RUN: `sys_rst`=0, `core_rst`=0, `ready`=1.
- Lock loss: `lock_s`=0 in STABLE, SYS_HOLD, CORE_HOLD or RUN → WAIT_LOCK.
  - Sets `rst_cause`=1 only when leaving SYS_HOLD, CORE_HOLD or RUN, i.e. after release began.
- `sw_rst_req`: honoured only in RUN.
  - RUN → CORE_HOLD, counter cleared, `rst_cause`=2.
  - `sys_rst` stays 0.
  - Ignored in all other states.
- Simultaneous lock loss and `sw_rst_req`: lock loss wins.
- `rst_cause` holds its value until the next cause event; `rst` sets it to 0.
- Counter width is `$clog2` of the largest count parameter, plus 1. The counter clears on every state entry and never wraps.
- All outputs are individual flops loaded from the next-state decode, so they are glitch-free.

## Timing
- `pll_locked` first sampled high at edge 0: `lock_s`=1 after edge SYNC_STAGES−1.
- STABLE entered after edge SYNC_STAGES.
- `sys_rst` falls after edge SYNC_STAGES+LOCK_STABLE_CYCLES+SYS_HOLD_CYCLES.
- `core_rst` falls and `ready` rises CORE_DELAY_CYCLES edges after `sys_rst` falls.
- Lock-loss response: `pll_locked` sampled low at edge n → both resets high and `ready` low after edge n+SYNC_STAGES.
- `sw_rst_req` sampled at edge n in RUN → `core_rst`=1 and `ready`=0 after edge n. RUN is re-entered after edge n+CORE_DELAY_CYCLES.
- `rst` mid-sequence: outputs assert immediately and the full sequence restarts from WAIT_LOCK.

## Configuration
- `DE10LITE_RST_SEQ_SWRST_EN` defined: `sw_rst_req` is honoured as described above.
- Undefined: `sw_rst_req` is ignored (port retained, unused), `rst_cause` never takes value 2, and no SW transition logic is synthesized.

## Structure
- Shared package `de10lite_sopc_pkg`:
  - state enum (WAIT_LOCK, STABLE, SYS_HOLD, CORE_HOLD, RUN)
  - `rst_cause` constants `RST_CAUSE_POR`, `RST_CAUSE_LOCK_LOSS`, `RST_CAUSE_SW`
- Sub-module `de10lite_sopc_bit_sync`:
  - parameterized SYNC_STAGES-deep flop chain with asynchronous reset to 0
  - reused for other CDC bits

## Test plan
Parameters LOCK_STABLE_CYCLES=8, SYS_HOLD_CYCLES=4, CORE_DELAY_CYCLES=4, SYNC_STAGES=2.
- Power-up, `pll_locked` sampled high at edge 0 → `sys_rst` falls after edge 14; `core_rst` falls and `ready` rises after edge 18; `rst_cause`=0.
- Lock glitch: `pll_locked` high for 5 cycles, then low for 1 cycle, then high → sequence restarts; `sys_rst` stays high until 14 edges after the final rise; `rst_cause`=0.
- Lock loss in RUN at edge n → `sys_rst`=`core_rst`=1 and `ready`=0 after edge n+2; `rst_cause`=1; relocking repeats the 14/18-edge release.
- `sw_rst_req` pulse in RUN at edge n (macro defined) → `core_rst`=1 after edge n, `sys_rst` stays 0, `ready` returns after edge n+4, `rst_cause`=2. With the macro undefined, there is no effect.
- Same-cycle lock loss and `sw_rst_req` → `rst_cause`=1, both resets high. Also: `sw_rst_req` during CORE_HOLD → ignored.
- `rst` pulse during SYS_HOLD → `sys_rst`/`core_rst` high asynchronously, `rst_cause`=0, state returns to WAIT_LOCK.

Source files
------------

// File: rtl/de10lite_sopc_pkg.sv
// de10lite_sopc_pkg
//   Shared types and constants for the DE10-Lite SoPC reset/clocking blocks.
//   - state_e      : reset sequencer state encoding
//   - RST_CAUSE_*  : encodings reported on rst_cause
//   - cnt_width()  : sizes a down-stream counter so it can hold the largest
//                    of three cycle counts without wrapping
package de10lite_sopc_pkg;

  typedef enum logic [2:0] {
    WAIT_LOCK = 3'd0,
    STABLE    = 3'd1,
    SYS_HOLD  = 3'd2,
    CORE_HOLD = 3'd3,
    RUN       = 3'd4
  } state_e;

  localparam logic [1:0] RST_CAUSE_POR       = 2'd0;
  localparam logic [1:0] RST_CAUSE_LOCK_LOSS = 2'd1;
  localparam logic [1:0] RST_CAUSE_SW        = 2'd2;

  // One extra bit above $clog2 of the largest count keeps headroom so the
  // terminal compare never aliases onto a wrapped value.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    else       m = m;
    if (c > m) m = c;
    else       m = m;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/de10lite_sopc_rst_seq_if.sv
// de10lite_sopc_rst_seq_if
//   Bundles the reset sequencer's lock/request inputs and reset outputs.
//   - pll_locked : PLL lock, asynchronous to the core clock
//   - sw_rst_req : single-cycle software core-reset request
//   - sys_rst    : interconnect/peripheral reset, active-high
//   - core_rst   : SCR1 core reset, active-high
//   - ready      : high only while the system runs
//   - rst_cause  : cause of the last reset (POR / lock loss / software)
//   Modports: slave = the sequencer, master = the side driving lock/request.
interface de10lite_sopc_rst_seq_if;

  logic       pll_locked;
  logic       sw_rst_req;
  logic       sys_rst;
  logic       core_rst;
  logic       ready;
  logic [1:0] rst_cause;

  modport master (
    output pll_locked, sw_rst_req,
    input  sys_rst, core_rst, ready, rst_cause
  );

  modport slave (
    input  pll_locked, sw_rst_req,
    output sys_rst, core_rst, ready, rst_cause
  );

endinterface

// File: rtl/de10lite_sopc_bit_sync.sv
// de10lite_sopc_bit_sync
//   Single-bit clock-domain-crossing synchronizer: SYNC_STAGES flops in series,
//   all cleared asynchronously by rst.
//   Ports: clk, rst (async, active-high), d (asynchronous input),
//          q (synchronized output, last stage).
module de10lite_sopc_bit_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_r;

  // Shift the asynchronous bit through the flop chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_r <= '0;
    else     sync_r <= {sync_r[SYNC_STAGES-2:0], d};
  end

  assign q = sync_r[SYNC_STAGES-1];

endmodule

// File: rtl/de10lite_sopc_rst_seq.sv
// de10lite_sopc_rst_seq
//   Reset sequencer behind the SoPC PLL. Qualifies the synchronized PLL lock
//   over a stable window, then releases sys_rst, then core_rst. Lock loss
//   re-asserts both resets; the cause of the last reset is reported.
//   Ports: clk (core clock), rst (async, active-high),
//          bus (slave modport: pll_locked, sw_rst_req in;
//               sys_rst, core_rst, ready, rst_cause out).
//   Build option: DE10LITE_RST_SEQ_SWRST_EN enables the software core-only
//   reset from RUN; without it sw_rst_req is ignored.
module de10lite_sopc_rst_seq
  import de10lite_sopc_pkg::*;
#(
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int SYS_HOLD_CYCLES    = 16,
  parameter int CORE_DELAY_CYCLES  = 16,
  parameter int SYNC_STAGES        = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  de10lite_sopc_rst_seq_if.slave   bus
);

  localparam int CNT_W = cnt_width(LOCK_STABLE_CYCLES, SYS_HOLD_CYCLES, CORE_DELAY_CYCLES);
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SYS_LAST  = CNT_W'(SYS_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CORE_LAST = CNT_W'(CORE_DELAY_CYCLES - 1);

  logic             lock_s;
  state_e           state_r, state_nxt_s;
  logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
  logic [1:0]       rst_cause_r, cause_nxt_s;
  logic             sys_rst_r, core_rst_r, ready_r;

  de10lite_sopc_bit_sync #(.SYNC_STAGES(SYNC_STAGES)) u_lock_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.pll_locked),
    .q   (lock_s)
  );

`ifndef DE10LITE_RST_SEQ_SWRST_EN
  logic unused_sw_s;
  assign unused_sw_s = bus.sw_rst_req;
`endif

  // Next-state decode: each window counts up to its last value and the
  // counter is cleared on every state entry, so it never wraps.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    cause_nxt_s = rst_cause_r;
    case (state_r)
      WAIT_LOCK: begin
        if (lock_s) begin
          state_nxt_s = STABLE;
          cnt_nxt_s   = '0;
        end else begin
          cnt_nxt_s = '0;
        end
      end
      STABLE: begin
        // Losing lock before release has begun is not a reportable cause.
        if (!lock_s) begin
          state_nxt_s = WAIT_LOCK;
          cnt_nxt_s   = '0;
        end else if (cnt_r == LOCK_LAST) begin
          state_nxt_s = SYS_HOLD;
          cnt_nxt_s   = '0;
        end else begin
          cnt_nxt_s = cnt_r + CNT_W'(1);
        end
      end
      SYS_HOLD: begin
        if (!lock_s) begin
          state_nxt_s = WAIT_LOCK;
          cnt_nxt_s   = '0;
          cause_nxt_s = RST_CAUSE_LOCK_LOSS;
        end else if (cnt_r == SYS_LAST) begin
          state_nxt_s = CORE_HOLD;
          cnt_nxt_s   = '0;
        end else begin
          cnt_nxt_s = cnt_r + CNT_W'(1);
        end
      end
      CORE_HOLD: begin
        if (!lock_s) begin
          state_nxt_s = WAIT_LOCK;
          cnt_nxt_s   = '0;
          cause_nxt_s = RST_CAUSE_LOCK_LOSS;
        end else if (cnt_r == CORE_LAST) begin
          state_nxt_s = RUN;
          cnt_nxt_s   = '0;
        end else begin
          cnt_nxt_s = cnt_r + CNT_W'(1);
        end
      end
      RUN: begin
        // Lock loss is tested first so it wins over a same-cycle request.
        if (!lock_s) begin
          state_nxt_s = WAIT_LOCK;
          cnt_nxt_s   = '0;
          cause_nxt_s = RST_CAUSE_LOCK_LOSS;
        end
`ifdef DE10LITE_RST_SEQ_SWRST_EN
        else if (bus.sw_rst_req) begin
          state_nxt_s = CORE_HOLD;
          cnt_nxt_s   = '0;
          cause_nxt_s = RST_CAUSE_SW;
        end
`endif
        else begin
          cnt_nxt_s = '0;
        end
      end
      default: begin
        state_nxt_s = WAIT_LOCK;
        cnt_nxt_s   = '0;
      end
    endcase
  end

  // State, counter, cause and output flops; outputs come from the next-state
  // decode so they change in the same cycle as the state and never glitch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= WAIT_LOCK;
      cnt_r       <= '0;
      rst_cause_r <= RST_CAUSE_POR;
      sys_rst_r   <= 1'b1;
      core_rst_r  <= 1'b1;
      ready_r     <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      cnt_r       <= cnt_nxt_s;
      rst_cause_r <= cause_nxt_s;
      sys_rst_r   <= (state_nxt_s == WAIT_LOCK) || (state_nxt_s == STABLE) ||
                     (state_nxt_s == SYS_HOLD);
      core_rst_r  <= (state_nxt_s != RUN);
      ready_r     <= (state_nxt_s == RUN);
    end
  end

  assign bus.sys_rst   = sys_rst_r;
  assign bus.core_rst  = core_rst_r;
  assign bus.ready     = ready_r;
  assign bus.rst_cause = rst_cause_r;

endmodule

// File: tb/tb_de10lite_sopc_rst_seq.sv
// tb_de10lite_sopc_rst_seq
//   Self-checking bench for de10lite_sopc_rst_seq with LOCK_STABLE_CYCLES=8,
//   SYS_HOLD_CYCLES=4, CORE_DELAY_CYCLES=4, SYNC_STAGES=2. Directed scenarios
//   followed by randomized lock drops, software requests and reset pulses.
//   The reference model tracks how long the synchronized lock has been
//   continuously high and derives the expected outputs from thresholds.
module tb_de10lite_sopc_rst_seq;
  import de10lite_sopc_pkg::*;

  localparam int L = 8;
  localparam int S = 4;
  localparam int C = 4;
  localparam int N = 2;
  localparam int T_REL  = 1 + L;          // lock-high edges when SYS_HOLD begins
  localparam int T_SYS  = 1 + L + S;      // lock-high edges when sys_rst drops
  localparam int T_CORE = 1 + L + S + C;  // lock-high edges when core_rst drops
`ifdef DE10LITE_RST_SEQ_SWRST_EN
  localparam bit SW_EN = 1'b1;
`else
  localparam bit SW_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  de10lite_sopc_rst_seq_if bus_if ();

  de10lite_sopc_rst_seq #(
    .LOCK_STABLE_CYCLES (L),
    .SYS_HOLD_CYCLES    (S),
    .CORE_DELAY_CYCLES  (C),
    .SYNC_STAGES        (N)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [N-1:0] m_hist;     // delay line of sampled pll_locked
  int           m_t;        // consecutive edges with synchronized lock high
  int           m_sw_left;  // remaining edges of a software core reset
  logic [1:0]   m_cause;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_hist    = '0;
    m_t       = 0;
    m_sw_left = 0;
    m_cause   = RST_CAUSE_POR;
  endtask

  // Advance the model by one clock edge using the inputs seen at that edge.
  task automatic model_edge();
    logic lock_pre;
    logic in_run;
    if (rst) begin
      model_reset();
    end else begin
      lock_pre = m_hist[N-1];
      m_hist   = {m_hist[N-2:0], bus_if.pll_locked};
      if (!lock_pre) begin
        if (m_t >= T_REL) m_cause = RST_CAUSE_LOCK_LOSS;
        m_t       = 0;
        m_sw_left = 0;
      end else begin
        in_run = (m_t >= T_CORE) && (m_sw_left == 0);
        if (m_t < T_CORE) m_t++;
        if (m_sw_left > 0) m_sw_left--;
        else if (SW_EN && in_run && bus_if.sw_rst_req) begin
          m_sw_left = C;
          m_cause   = RST_CAUSE_SW;
        end
      end
    end
  endtask

  task automatic check_outputs(input string ph);
    logic exp_sys, exp_core;
    exp_sys  = (m_t < T_SYS);
    exp_core = (m_t < T_CORE) || (m_sw_left > 0);
    check_eq({ph, "_sys_rst"},  bus_if.sys_rst,   exp_sys);
    check_eq({ph, "_core_rst"}, bus_if.core_rst,  exp_core);
    check_eq({ph, "_ready"},    bus_if.ready,     !exp_core);
    check_eq({ph, "_cause"},    bus_if.rst_cause, m_cause);
  endtask

  task automatic step(input string ph);
    @(posedge clk);
    model_edge();
    #1;
    check_outputs(ph);
  endtask

  // Short rst pulse between edges; outputs must react without a clock.
  task automatic rst_pulse();
    #1 rst = 1'b1;
    #1;
    model_reset();
    check_outputs("async_rst");
    #1 rst = 1'b0;
  endtask

  // Run 20 edges from a fresh lock rise and pin the release edges.
  task automatic release_seq(input string ph);
    for (int e = 0; e < 20; e++) begin
      step(ph);
      if (e == T_SYS - 1 + N - 1)  check_eq({ph, "_sys_before"},  bus_if.sys_rst,  1'b1);
      if (e == T_SYS + N - 1)      check_eq({ph, "_sys_after"},   bus_if.sys_rst,  1'b0);
      if (e == T_CORE - 1 + N - 1) check_eq({ph, "_core_before"}, bus_if.core_rst, 1'b1);
      if (e == T_CORE + N - 1)     check_eq({ph, "_ready_after"}, bus_if.ready,    1'b1);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus_if.pll_locked = 1'b0;
    bus_if.sw_rst_req = 1'b0;
    model_reset();
    #1;
    check_outputs("por");
    step("por");
    step("por");
    rst = 1'b0;

    // Power-up: lock sampled high at edge 0 -> sys_rst drops after 14, core after 18
    bus_if.pll_locked = 1'b1;
    release_seq("pwr");
    check_eq("pwr_cause", bus_if.rst_cause, RST_CAUSE_POR);

    // Lock glitch during qualification restarts the window
    rst_pulse();
    bus_if.pll_locked = 1'b0;
    step("glitch"); step("glitch");
    bus_if.pll_locked = 1'b1;
    repeat (5) step("glitch");
    bus_if.pll_locked = 1'b0;
    step("glitch");
    bus_if.pll_locked = 1'b1;
    release_seq("glitch");
    check_eq("glitch_cause", bus_if.rst_cause, RST_CAUSE_POR);

    // Lock loss in RUN: both resets back after n+2
    bus_if.pll_locked = 1'b0;
    step("loss"); step("loss"); step("loss");
    check_eq("loss_sys",   bus_if.sys_rst,   1'b1);
    check_eq("loss_cause", bus_if.rst_cause, RST_CAUSE_LOCK_LOSS);
    bus_if.pll_locked = 1'b1;
    release_seq("relock");

    // Software core reset from RUN
    bus_if.sw_rst_req = 1'b1;
    step("sw");
    bus_if.sw_rst_req = 1'b0;
    check_eq("sw_core", bus_if.core_rst, SW_EN);
    check_eq("sw_sys",  bus_if.sys_rst,  1'b0);
    // Request during the software CORE_HOLD is ignored
    step("sw");
    bus_if.sw_rst_req = 1'b1;
    step("sw");
    bus_if.sw_rst_req = 1'b0;
    step("sw"); step("sw");
    check_eq("sw_ready", bus_if.ready, 1'b1);
    check_eq("sw_cause", bus_if.rst_cause, SW_EN ? RST_CAUSE_SW : RST_CAUSE_LOCK_LOSS);
    repeat (4) step("sw");

    // Same-cycle lock loss and software request: lock loss wins
    bus_if.pll_locked = 1'b0;
    step("both"); step("both");
    bus_if.sw_rst_req = 1'b1;
    step("both");
    bus_if.sw_rst_req = 1'b0;
    check_eq("both_cause", bus_if.rst_cause, RST_CAUSE_LOCK_LOSS);
    check_eq("both_sys",   bus_if.sys_rst,   1'b1);
    bus_if.pll_locked = 1'b1;
    // Request during power-up CORE_HOLD is ignored too
    for (int e = 0; e < 20; e++) begin
      bus_if.sw_rst_req = (e == 15);
      step("chold");
    end
    bus_if.sw_rst_req = 1'b0;

    // rst pulse while in SYS_HOLD
    rst_pulse();
    bus_if.pll_locked = 1'b1;
    repeat (12) step("syshold");
    check_eq("syshold_sys", bus_if.sys_rst, 1'b1);
    rst_pulse();
    check_eq("syshold_cause", bus_if.rst_cause, RST_CAUSE_POR);
    release_seq("after_rst");

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bus_if.pll_locked = ($urandom_range(0, 39) != 0);
      bus_if.sw_rst_req = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 399) == 0) rst_pulse();
      step("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
